// File: rtl/alu_ctrl_pkg.sv
// Shared types and encodings for the ALU control unit: widths, FSM state codes,
// ALU function selects and instruction-class codes.
package alu_ctrl_pkg;

    localparam int NREG = 4;
    localparam int DW   = 8;
    localparam int AW   = 8;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE      = 3'd0;
    localparam state_t S_FETCH     = 3'd1;
    localparam state_t S_DECODE    = 3'd2;
    localparam state_t S_EXEC      = 3'd3;
    localparam state_t S_FETCH_IMM = 3'd4;
    localparam state_t S_HALT      = 3'd5;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_AND  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_ADD  = 3'b011;
    localparam logic [2:0] ALU_SUB  = 3'b100;
    localparam logic [2:0] ALU_NOT  = 3'b101;
    localparam logic [2:0] ALU_INC  = 3'b110;
    localparam logic [2:0] ALU_DEC  = 3'b111;

    localparam logic [1:0] CLS_LDI     = 2'b00;
    localparam logic [1:0] CLS_MOVTO   = 2'b01;
    localparam logic [1:0] CLS_MOVFROM = 2'b10;
    localparam logic [1:0] CLS_HALT    = 2'b11;

    // Bits [3:2] of an instruction carry no meaning, so they are never stored.
    typedef struct packed {
        logic       ctl;
        logic [2:0] func;
        logic [1:0] rs;
    } instr_t;

endpackage

// File: rtl/alu_ctrl_if.sv
// Bus bundle between the control unit, program memory and the ALU.
interface alu_ctrl_if;
    import alu_ctrl_pkg::*;

    logic          instr_req;
    logic [AW-1:0] instr_addr;
    logic          instr_ack;
    logic [7:0]    instr_data;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [2:0]    alu_sel;
    logic [DW-1:0] alu_y;

    modport master (
        output instr_req, instr_addr, alu_a, alu_b, alu_sel,
        input  instr_ack, instr_data, alu_y
    );

    modport slave (
        input  instr_req, instr_addr, alu_a, alu_b, alu_sel,
        output instr_ack, instr_data, alu_y
    );

endinterface

// File: rtl/alu_ctrl_regfile.sv
// Scratch register file: NREG x DW, one synchronous write port, one async read port.
module alu_ctrl_regfile
    import alu_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [1:0]    waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [1:0]    raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] regs_q [NREG];

    // Register storage with async clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= {DW{1'b0}};
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end else begin
            regs_q <= regs_q;
        end
    end

    assign rdata_o = regs_q[raddr_i];

endmodule

// File: rtl/alu_ctrl.sv
// Multi-cycle control unit: fetches byte instructions over req/ack, drives the
// external ALU with registered operands and writes results back to an accumulator.
module alu_ctrl
    import alu_ctrl_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    alu_ctrl_if.master    bus,
    output logic [DW-1:0] acc_o,
    output logic          zero_o,
    output logic          halted_o
);

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    instr_t        ir_q, ir_d;
    logic [DW-1:0] acc_q, acc_d;
    logic          zero_q, zero_d;
    logic          halted_q, halted_d;
    logic [DW-1:0] alu_a_q, alu_a_d;
    logic [DW-1:0] alu_b_q, alu_b_d;
    logic [2:0]    alu_sel_q, alu_sel_d;

    logic          rf_we_s;
    logic [DW-1:0] rf_wdata_s;
    logic [DW-1:0] rf_rdata_s;
    logic          ack_s;

    alu_ctrl_regfile u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (rf_we_s),
        .waddr_i (ir_q.rs),
        .wdata_i (rf_wdata_s),
        .raddr_i (ir_q.rs),
        .rdata_o (rf_rdata_s)
    );

    // Ack only counts while a fetch is outstanding; req is a pure state decode.
    assign bus.instr_req  = (state_q == S_FETCH) || (state_q == S_FETCH_IMM);
    assign ack_s          = bus.instr_req && bus.instr_ack;
    assign bus.instr_addr = pc_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_sel    = alu_sel_q;
    assign acc_o          = acc_q;
    assign zero_o         = zero_q;
    assign halted_o       = halted_q;

    // Next-state and datapath update logic.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        acc_d      = acc_q;
        zero_d     = zero_q;
        halted_d   = halted_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_sel_d  = alu_sel_q;
        rf_we_s    = 1'b0;
        rf_wdata_s = acc_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (ack_s) begin
                    ir_d    = '{ctl: bus.instr_data[7], func: bus.instr_data[6:4],
                                rs: bus.instr_data[1:0]};
                    pc_d    = pc_q + 8'd1;
                    state_d = S_DECODE;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DECODE: begin
                if (!ir_q.ctl) begin
                    alu_a_d   = acc_q;
                    alu_b_d   = rf_rdata_s;
                    alu_sel_d = ir_q.func;
                    state_d   = S_EXEC;
                end else begin
                    case (ir_q.func[2:1])
                        CLS_LDI: state_d = S_FETCH_IMM;
                        CLS_MOVTO: begin
                            rf_we_s = 1'b1;
                            state_d = S_FETCH;
                        end
                        CLS_MOVFROM: begin
                            acc_d   = rf_rdata_s;
                            state_d = S_FETCH;
                        end
                        CLS_HALT: begin
                            halted_d = 1'b1;
                            state_d  = S_HALT;
                        end
                        default: state_d = S_FETCH;
                    endcase
                end
            end
            S_EXEC: begin
                acc_d   = bus.alu_y;
                zero_d  = (bus.alu_y == 8'h00);
                state_d = S_FETCH;
            end
            S_FETCH_IMM: begin
                if (ack_s) begin
                    rf_we_s    = 1'b1;
                    rf_wdata_s = bus.instr_data;
                    pc_d       = pc_q + 8'd1;
                    state_d    = S_FETCH;
                end else begin
                    state_d = S_FETCH_IMM;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pc_q      <= 8'h00;
            ir_q      <= '{ctl: 1'b0, func: 3'b000, rs: 2'b00};
            acc_q     <= 8'h00;
            zero_q    <= 1'b0;
            halted_q  <= 1'b0;
            alu_a_q   <= 8'h00;
            alu_b_q   <= 8'h00;
            alu_sel_q <= ALU_PASS;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            acc_q     <= acc_d;
            zero_q    <= zero_d;
            halted_q  <= halted_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed self-checking bench for alu_ctrl with a program-memory and ALU model.
module tb_alu_ctrl;
    import alu_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] acc;
    logic       zero;
    logic       halted;
    logic [7:0] mem [256];
    int         wait_cfg = 0;
    int         wait_cnt = 0;
    logic       stray_en = 1'b0;
    logic       ack_taken = 1'b0;
    logic       prev_req = 1'b0;
    logic [7:0] prev_addr = 8'h00;
    int         stab_err = 0;
    int         n_cmp = 0;
    int         n_err = 0;

    alu_ctrl_if bus ();

    alu_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .acc_o    (acc),
        .zero_o   (zero),
        .halted_o (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [2:0] sel);
        case (sel)
            ALU_PASS: return a;
            ALU_AND:  return a & b;
            ALU_OR:   return a | b;
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_NOT:  return ~a;
            ALU_INC:  return a + 8'd1;
            ALU_DEC:  return a - 8'd1;
            default:  return 8'h00;
        endcase
    endfunction

    assign bus.alu_y      = alu_model(bus.alu_a, bus.alu_b, bus.alu_sel);
    assign bus.instr_data = mem[bus.instr_addr];
    assign bus.instr_ack  = bus.instr_req ? (wait_cnt >= wait_cfg) : stray_en;

    always @(posedge clk) begin
        if (bus.instr_req && !bus.instr_ack) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        ack_taken <= bus.instr_req && bus.instr_ack;
    end

    // An outstanding request must hold its address until it is acknowledged.
    always @(negedge clk) begin
        if (rst_n && prev_req && !ack_taken &&
            (!bus.instr_req || bus.instr_addr != prev_addr)) begin
            stab_err <= stab_err + 1;
        end
        prev_req  <= rst_n && bus.instr_req;
        prev_addr <= bus.instr_addr;
    end

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_fetch(input logic [7:0] target, input int budget, input string tag);
        int n = 0;
        while (!(bus.instr_req === 1'b1 && bus.instr_addr === target) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (n >= budget) check_value(tag, {24'h0, bus.instr_addr}, {24'h0, target});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int quiet_bad;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[0] = 8'h81; mem[1] = 8'h05; mem[2] = 8'hC1; mem[3] = 8'h31;
        mem[4] = 8'h41; mem[5] = 8'h41; mem[6] = 8'h70; mem[7] = 8'hE0;
        rst_n = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_value("rst_req",    bus.instr_req,  1'b0);
        check_value("rst_addr",   bus.instr_addr, 8'h00);
        check_value("rst_a",      bus.alu_a,      8'h00);
        check_value("rst_b",      bus.alu_b,      8'h00);
        check_value("rst_sel",    bus.alu_sel,    3'b000);
        check_value("rst_acc",    acc,            8'h00);
        check_value("rst_zero",   zero,           1'b0);
        check_value("rst_halted", halted,         1'b0);
        rst_n = 1'b1;
        check_value("idle_req", bus.instr_req, 1'b0);
        @(negedge clk);
        check_value("first_req",  bus.instr_req,  1'b1);
        check_value("first_addr", bus.instr_addr, 8'h00);

        // LDI R1,5 ; acc<=R1 ; ADD R1 with zero-wait memory
        wait_fetch(8'h03, 30, "s2_to3");
        check_value("s2_mov_acc", acc, 8'h05);
        wait_fetch(8'h04, 30, "s2_to4");
        check_value("s2_add_acc",  acc,            8'h0A);
        check_value("s2_add_zero", zero,           1'b0);
        check_value("s2_add_sel",  bus.alu_sel,    3'b011);
        check_value("s2_add_a",    bus.alu_a,      8'h05);
        check_value("s2_add_b",    bus.alu_b,      8'h05);
        check_value("s2_addr",     bus.instr_addr, 8'h04);

        // SUB, SUB to zero, DEC wraps
        wait_fetch(8'h05, 30, "s3_to5");
        check_value("s3_sub1_acc",  acc,  8'h05);
        check_value("s3_sub1_zero", zero, 1'b0);
        wait_fetch(8'h06, 30, "s3_to6");
        check_value("s3_sub2_acc",  acc,  8'h00);
        check_value("s3_sub2_zero", zero, 1'b1);
        wait_fetch(8'h07, 30, "s3_to7");
        check_value("s3_dec_acc",  acc,         8'hFF);
        check_value("s3_dec_zero", zero,        1'b0);
        check_value("s3_dec_sel",  bus.alu_sel, 3'b111);
        check_value("s3_dec_a",    bus.alu_a,   8'h00);
        check_value("s3_dec_b",    bus.alu_b,   8'h00);

        // HALT fetched at 0x07 (acked this cycle)
        check_value("s5_halt_pre", halted, 1'b0);
        @(negedge clk);
        check_value("s5_halt_decode", halted, 1'b0);
        @(negedge clk);
        check_value("s5_halted", halted,        1'b1);
        check_value("s5_req",    bus.instr_req, 1'b0);
        stray_en  = 1'b1;
        quiet_bad = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (bus.instr_req !== 1'b0) quiet_bad++;
        end
        check_value("s5_req_quiet",  quiet_bad,      0);
        check_value("s5_addr_hold",  bus.instr_addr, 8'h08);
        check_value("s5_acc_hold",   acc,            8'hFF);
        check_value("s5_sel_hold",   bus.alu_sel,    3'b111);
        wait_cfg = 3;
        do_reset();
        check_value("s5_unhalt", halted, 1'b0);

        // Same program with 3 wait states per fetch and stray acks while idle
        @(negedge clk);
        check_value("s4_restart_req",  bus.instr_req,  1'b1);
        check_value("s4_restart_addr", bus.instr_addr, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_value("s4_wait_req",  bus.instr_req,  1'b1);
            check_value("s4_wait_addr", bus.instr_addr, 8'h00);
        end
        wait_fetch(8'h03, 60, "s4_to3");
        check_value("s4_mov_acc", acc, 8'h05);
        wait_fetch(8'h04, 60, "s4_to4");
        check_value("s4_add_acc",  acc,         8'h0A);
        check_value("s4_add_zero", zero,        1'b0);
        check_value("s4_add_sel",  bus.alu_sel, 3'b011);
        check_value("s4_add_b",    bus.alu_b,   8'h05);
        check_value("s4_stable",   stab_err,    0);
        stray_en = 1'b0;

        // Reset while waiting for the LDI immediate
        do_reset();
        wait_fetch(8'h01, 30, "s6_to_imm");
        #2 rst_n = 1'b0;
        #1;
        check_value("s6_req_async",  bus.instr_req,  1'b0);
        check_value("s6_addr_async", bus.instr_addr, 8'h00);
        mem[0]   = 8'hC1;
        mem[1]   = 8'h02;
        wait_cfg = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_fetch(8'h01, 30, "s6_readback");
        check_value("s6_r1_kept", acc, 8'h00);

        // pc wrap through a chain of pass-acc instructions
        for (int i = 0; i < 256; i++) mem[i] = 8'h02;
        do_reset();
        wait_fetch(8'hFF, 1200, "s6_to_ff");
        @(negedge clk);
        wait_fetch(8'h00, 10, "s6_wrap");
        check_value("s6_wrap_addr", bus.instr_addr, 8'h00);
        check_value("s6_wrap_acc",  acc,            8'h00);
        check_value("s6_wrap_zero", zero,           1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
